// File: rtl/alu_pipe_w.sv
// rtl/alu_pipe_w.sv - registered Y86 ALU slice (ADD/SUB/AND/XOR) with valid/ready handshake and op counter
// Optional condition-code register (ZF/SF/OF) is built only when ALU_PIPE_CC_EN is defined.
module alu_pipe_w #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  state_t           r_state;
  logic [WIDTH-1:0] r_ans;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;

  // A consumed result frees the register in the same cycle, so a full stage still streams.
  assign in_ready  = (r_state == S_EMPTY) || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_FULL);
  assign ans       = r_ans;
  assign op_count  = r_count;

  always_comb begin
    w_result = '0;
    case (op)
      OP_ADD:  w_result = a + b;
      OP_SUB:  w_result = a - b;
      OP_AND:  w_result = a & b;
      OP_XOR:  w_result = a ^ b;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_ans   <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state <= S_FULL;
            r_ans   <= w_result;
          end
        end
        S_FULL: begin
          if (w_accept) begin
            r_ans <= w_result;
          end else if (out_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_accept && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

`ifdef ALU_PIPE_CC_EN
  logic w_zf;
  logic w_sf;
  logic w_of;
  logic r_zf;
  logic r_sf;
  logic r_of;

  // Signed overflow: result sign disagrees with a when the operand signs make that impossible.
  always_comb begin
    w_zf = (w_result == '0);
    w_sf = w_result[WIDTH-1];
    w_of = 1'b0;
    case (op)
      OP_ADD:  w_of = (a[WIDTH-1] == b[WIDTH-1]) && (w_result[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  w_of = (a[WIDTH-1] != b[WIDTH-1]) && (w_result[WIDTH-1] != a[WIDTH-1]);
      default: w_of = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_accept && set_cc) begin
      r_zf <= w_zf;
      r_sf <= w_sf;
      r_of <= w_of;
    end
  end

  assign zf = r_zf;
  assign sf = r_sf;
  assign of = r_of;
`else
  logic w_unused_cc;
  assign w_unused_cc = set_cc;
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe_w.sv
// tb/tb_alu_pipe_w.sv - self-checking bench for alu_pipe_w (table vectors, corner sequences, random vs model)
module tb_alu_pipe_w;

`ifdef ALU_PIPE_CC_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        set_cc = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, zf, sf, of;
  logic [63:0] ans;
  logic [15:0] op_count;

  logic        in_ready1, out_valid1, zf1, sf1, of1;
  logic [7:0]  ans1;
  logic [1:0]  op_count1;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit          m_valid;
  logic [63:0] m_ans;
  bit          m_zf, m_sf, m_of;
  int          m_cnt;

  always #5 clk = ~clk;

  alu_pipe_w #(.WIDTH(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .set_cc(set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .ans(ans),
    .zf(zf), .sf(sf), .of(of), .op_count(op_count)
  );

  alu_pipe_w #(.WIDTH(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .a(a[7:0]), .b(b[7:0]), .set_cc(set_cc),
    .out_valid(out_valid1), .out_ready(out_ready), .ans(ans1),
    .zf(zf1), .sf(sf1), .of(of1), .op_count(op_count1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    case (o)
      2'd0: return x + y;
      2'd1: return x - y;
      2'd2: return x & y;
      default: return x ^ y;
    endcase
  endfunction

  // Overflow as "true signed result does not fit in 64 bits".
  function automatic bit ref_of(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    logic signed [64:0] sx, sy, s;
    sx = $signed({x[63], x});
    sy = $signed({y[63], y});
    if (o == 2'd0) s = sx + sy;
    else if (o == 2'd1) s = sx - sy;
    else return 1'b0;
    return (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_ans   = '0;
    m_zf    = CC_EN;
    m_sf    = 0;
    m_of    = 0;
    m_cnt   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".ans"}, ans, m_ans);
    check({tag, ".zf"}, 64'(zf), 64'(m_zf));
    check({tag, ".sf"}, 64'(sf), 64'(m_sf));
    check({tag, ".of"}, 64'(of), 64'(m_of));
    check({tag, ".op_count"}, 64'(op_count), 64'(m_cnt > 65535 ? 65535 : m_cnt));
    check({tag, ".op_count_sat2"}, 64'(op_count1), 64'(m_cnt > 3 ? 3 : m_cnt));
  endtask

  // One clock: check in_ready before the edge, advance the model, compare after the edge.
  task automatic step(input string tag);
    bit acc;
    logic [63:0] r;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || out_ready));
    acc = in_valid && (!m_valid || out_ready);
    @(posedge clk);
    #1;
    if (acc) begin
      r = ref_res(op, a, b);
      m_ans   = r;
      m_valid = 1;
      if (set_cc && CC_EN) begin
        m_zf = (r == 0);
        m_sf = r[63];
        m_of = ref_of(op, a, b);
      end
      m_cnt++;
    end else if (out_ready) begin
      m_valid = 0;
    end
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] o, input logic [63:0] x,
                       input logic [63:0] y, input bit cc, input bit rdy);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    set_cc    = cc;
    out_ready = rdy;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [63:0] exp_ans;
    logic        exp_zf;
    logic        exp_sf;
    logic        exp_of;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'd2, 64'hC350, 64'hC310, 1'b1, 64'hC310, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{2'd1, 64'd5, 64'd5, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 64'h6, 64'h1, 1'b0, 64'h7, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check("reset.in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].set_cc, 1);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_ans", i), ans, vecs[i].exp_ans);
      check($sformatf("vec%0d.tbl_zf", i), 64'(zf), 64'(vecs[i].exp_zf & CC_EN));
      check($sformatf("vec%0d.tbl_sf", i), 64'(sf), 64'(vecs[i].exp_sf & CC_EN));
      check($sformatf("vec%0d.tbl_of", i), 64'(of), 64'(vecs[i].exp_of & CC_EN));
      check($sformatf("vec%0d.tbl_cnt", i), 64'(op_count), 64'(i + 1));
    end

    // Backpressure: 2+3 held for three stalled cycles, then released into 10+10.
    drive(1, 2'd0, 64'd2, 64'd3, 1, 1);
    step("bp_acc");
    drive(1, 2'd0, 64'd10, 64'd10, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("bp_stall%0d", k));
      check("bp.ans_held", ans, 64'd5);
      check("bp.in_ready_low", 64'(in_ready), 64'd0);
      check("bp.cnt_held", 64'(op_count), 64'd9);
    end
    out_ready = 1;
    step("bp_release");
    check("bp.release_ans", ans, 64'd20);
    check("bp.release_cnt", 64'(op_count), 64'd10);
    drive(0, 2'd1, 64'd1, 64'd1, 1, 1);
    step("drain");
    check("drain.out_valid", 64'(out_valid), 64'd0);
    check("drain.ans_kept", ans, 64'd20);
    step("idle");

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        1: rb = 64'h8000_0000_0000_0000;
        2: rb = ra;
        default: ;
      endcase
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), ra, rb,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      step("rand");
    end

    // Asynchronous reset while a result is stalled.
    drive(1, 2'd0, 64'd7, 64'd8, 1, 0);
    step("pre_rst");
    drive(0, 2'd0, 64'd0, 64'd0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of the narrow counter: five accepts.
    for (int k = 0; k < 5; k++) begin
      drive(1, 2'd3, 64'(k), 64'd1, 1, 1);
      step($sformatf("sat%0d", k));
      check("sat.cnt2", 64'(op_count1), 64'(k + 1 > 3 ? 3 : k + 1));
    end
    check("sat.flags_small_off", 64'({zf1, sf1, of1}) & 64'(CC_EN ? 0 : 7), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe_w.md
# alu_pipe_w

Parametrised, registered successor to the combinational 64-bit ALU slices (AND, ADD, SUB, XOR) used in the Y86 execute stage. It accepts one operation per cycle over a valid/ready handshake and returns a registered result one cycle later, holding it under backpressure. It maintains the Y86 condition-code register (ZF, SF, OF) and a saturating count of accepted operations. It sits between decode and the memory/write-back stages of the pipelined processor.

## Interface
- `WIDTH`, 64: operand and result width in bits; legal when ≥ 2.
- `CNT_W`, 16: width of the accepted-operation counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept an operation this cycle.
- `op`  in  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 XOR.
- `a`  in  WIDTH  first operand.
- `b`  in  WIDTH  second operand.
- `set_cc`  in  1  update the condition codes from this operation.
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  downstream consumes the result this cycle.
- `ans`  out  WIDTH  registered result.
- `zf`, `sf`, `of`  out  1 each  condition-code register.
- `op_count`  out  CNT_W  number of accepted operations, saturating.

## Operation
- Accept occurs when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational, so a full pipeline still passes one operation per cycle.
- Results, all modulo 2^WIDTH and treating operands as two's complement:
  - ADD: `a + b`.
  - SUB: `a - b`.
  - AND: `a & b`.
  - XOR: `a ^ b`.
- Flags for the result r:
  - ZF = (r == 0).
  - SF = r[WIDTH-1].
  - OF for ADD: a and b have equal sign and r's sign differs from a.
  - OF for SUB: a and b have differing sign and r's sign differs from a.
  - OF for AND and XOR: 0.
  - Carry is not produced.
- On accept, `ans` loads r and `out_valid` is set.
- When `out_valid && out_ready` with no accept in the same cycle, `out_valid` clears. `ans` keeps its last value.
- Consume and accept in the same cycle: `ans` loads the new r and `out_valid` stays 1.
- While `out_valid && !out_ready`, `ans` and `out_valid` hold. `in_ready` is 0, so inputs are ignored.
- Condition codes (see Configuration):
  - Update on an accept with `set_cc = 1`, from the flags of the accepted r.
  - Hold otherwise, including during backpressure.
- Operation counter:
  - Increments on each accept.
  - Saturates at 2^CNT_W − 1 and never wraps.

State summary, with a two-state output FSM:
- EMPTY → FULL on accept.
- FULL → EMPTY on consume without accept.
- FULL → FULL on consume with accept, or on stall.

## Timing
- Latency: an operation accepted at rising edge k is visible on `ans`/`out_valid` immediately after edge k.
- Throughput: 1 operation per cycle when `out_ready` is held at 1.
- Condition codes reflect the accepted operation after the same edge k that loads `ans`.
- Reset (`rst_n` = 0, asynchronous, effective immediately regardless of clock):
  - `out_valid` = 0, `ans` = 0.
  - `zf` = 1, `sf` = 0, `of` = 0.
  - `op_count` = 0.
  - `in_ready` = 1 once reset is applied.
- Reset mid-operation discards any held result. No output handshake completes for it.
- Deassertion of `rst_n` is synchronised externally. The first accept can occur on the first rising edge with `rst_n` = 1.
- `in_valid` may drop without an accept; no state changes in that case.

## Configuration
- Macro: `ALU_PIPE_CC_EN`.
- Defined: the condition-code register and its `set_cc` update logic are built as described above.
- Undefined:
  - `zf`, `sf`, `of` are tied to 0.
  - `set_cc` is ignored.
  - No condition-code flops are built.
  - Results, handshake and `op_count` are unchanged.

## Test plan
- Reset, then AND with a=0xC350, b=0xC310, set_cc=1 → one cycle later `ans`=0xC310, zf=0, sf=0, of=0, op_count=1.
- ADD with a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1 → `ans`=0x8000_0000_0000_0000, sf=1, of=1, zf=0.
- SUB 5−5 with set_cc=1, then XOR 0x6^0x1 with set_cc=0, back-to-back, out_ready=1 → `ans`=0 then 0x7. zf stays 1 after the XOR. op_count increments by 2.
- Backpressure: accept ADD 2+3, then hold out_ready=0 for 3 cycles with in_valid=1 → `ans` stays 5, in_ready=0, op_count unchanged. Release → next operation accepted on the release cycle.
- Reset asserted while out_valid=1 and stalled → out_valid, ans and op_count go to 0 and zf to 1 without a clock edge.
- CNT_W=2, five accepts → op_count reads 3 and holds. With `ALU_PIPE_CC_EN` undefined, the flags stay 0 throughout.
